// File: rtl/apb_pkg.sv
// Purpose : shared types and constants for the APB4 memory slave and its RAM.
// Latency : n/a (declarations only).
// Backpressure : n/a.
//
// Contents:
//   apb_state_e  - slave FSM states (IDLE, ACCESS)
//   APB_OKAY/ERR - pslverr response encodings
//   apb_lsb()    - byte-offset width of a bus word (clog2 of bytes per word)
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  // Number of byte-offset address bits below the word index.
  function automatic int apb_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_be_ram.sv
// Purpose : DEPTH x DATA_WIDTH word array, per-byte write enables, synchronous read port.
// Latency : write lands on the enabling edge; read data appears the edge after i_re.
// Backpressure : none; caller sequences reads and writes so they never share an edge.
//
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset (clears the read register only)
//   i_we, i_be       - write enable and byte-lane enables
//   i_wdata          - write data
//   i_re, i_rclr     - read enable; i_rclr loads zero instead of the array word
//   i_addr           - shared word address for read and write
//   o_rdata          - registered read data, holds between reads
module apb_be_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic                    i_rclr,
  input  logic [AW-1:0]           i_addr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read register doubles as the bus read-data register, so it is the only
  // part of this block that sees reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rclr ? '0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/apb4_mem_slave.sv
// Purpose : APB4 memory-mapped slave with byte strobes, fixed wait states and error responses.
// Latency : setup + 1 + WAIT_CYCLES cycles per transfer; pready/pslverr/prdata are registered.
// Backpressure : stalls the master with pready=0 for WAIT_CYCLES access cycles.
//
// Ports:
//   i_pclk, i_preset            - clock, synchronous active-high reset
//   i_psel, i_penable, i_pwrite - APB select, access phase, direction
//   i_paddr, i_pwdata, i_pstrb  - byte address, write data, write byte lanes
//   i_pprot                     - protection; bit 0 = privileged
//   o_pready, o_prdata, o_pslverr - registered completion, read data, error response
import apb_pkg::*;

module apb4_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int PRIV_ONLY   = 0
) (
  input  logic                    i_pclk,
  input  logic                    i_preset,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic                    i_pwrite,
  input  logic [ADDR_WIDTH-1:0]   i_paddr,
  input  logic [DATA_WIDTH-1:0]   i_pwdata,
  input  logic [DATA_WIDTH/8-1:0] i_pstrb,
  input  logic [2:0]              i_pprot,
  output logic                    o_pready,
  output logic [DATA_WIDTH-1:0]   o_prdata,
  output logic                    o_pslverr
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LSB    = apb_lsb(DATA_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  apb_state_e          r_state;
  logic [7:0]          r_wcnt;
  logic [RAM_AW-1:0]   r_index;
  logic                r_write;
  logic                r_err;
  logic                r_pready;
  logic                r_pslverr;

  // ---------------------------------------------------------------------------
  // Setup-phase decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]    w_index;
  logic                w_oob;
  logic                w_misalign;
  logic                w_priv_fail;
  logic                w_err;
  logic                w_setup;
  logic                w_raise_now;
  logic                w_raise_later;
  logic                w_rd_en;
  logic                w_rd_clr;
  logic                w_we;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic                w_unused_prot;

  assign w_index     = i_paddr[ADDR_WIDTH-1:LSB];
  assign w_oob       = (32'(w_index) >= 32'(DEPTH));
  assign w_misalign  = (i_paddr & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign w_priv_fail = (PRIV_ONLY != 0) && !i_pprot[0];
  assign w_err       = w_oob || w_misalign || w_priv_fail;

  // Only the privilege bit of pprot carries meaning here.
  assign w_unused_prot = ^i_pprot[2:1];

  assign w_setup = (r_state == IDLE) && i_psel && !i_penable;

  // pready is registered, so it must be raised on the edge that enters the
  // completion cycle: the setup edge itself when there are no wait states,
  // otherwise the edge where the counter steps from 1 to 0.
  assign w_raise_now   = w_setup && (WAIT_CYCLES == 0);
  assign w_raise_later = (r_state == ACCESS) && i_psel && !r_pready && (r_wcnt == 8'd1);

  // The read word is fetched on that same edge, so prdata is valid together
  // with pready. An errored read fetches zero.
  assign w_rd_en  = (w_raise_now && !i_pwrite) || (w_raise_later && !r_write);
  assign w_rd_clr = w_raise_now ? w_err : r_err;

  // Write commits on the completing edge only; an abort or reset on that
  // edge discards it.
  assign w_we = (r_state == ACCESS) && i_psel && i_penable && r_pready &&
                r_write && !r_err && !i_preset;

  // In IDLE the only RAM access is a zero-wait read straight from the bus
  // address; everything else uses the index latched at setup.
  assign w_ram_addr = (r_state == IDLE) ? w_index[RAM_AW-1:0] : r_index;

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_index   <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= APB_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_index <= w_index[RAM_AW-1:0];
            r_write <= i_pwrite;
            r_err   <= w_err;
            r_wcnt  <= 8'(WAIT_CYCLES);
            r_state <= ACCESS;
            if (WAIT_CYCLES == 0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err ? APB_ERR : APB_OKAY;
            end
          end
        end

        ACCESS: begin
          if (!i_psel) begin
            // Master gave up: leave without completing.
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= APB_OKAY;
          end else if (r_pready) begin
            // Completion cycle; pready is a single-cycle pulse.
            r_state   <= IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= APB_OKAY;
          end else if (r_wcnt != 8'd0) begin
            r_wcnt <= r_wcnt - 8'd1;
            if (r_wcnt == 8'd1) begin
              r_pready  <= 1'b1;
              r_pslverr <= r_err ? APB_ERR : APB_OKAY;
            end
          end else begin
            // Unreachable with a consistent counter; recover to IDLE.
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  apb_be_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (RAM_AW)
  ) u_ram (
    .i_clk   (i_pclk),
    .i_rst   (i_preset),
    .i_we    (w_we),
    .i_be    (i_pstrb),
    .i_wdata (i_pwdata),
    .i_re    (w_rd_en),
    .i_rclr  (w_rd_clr),
    .i_addr  (w_ram_addr),
    .o_rdata (o_prdata)
  );

  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;

endmodule
